// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the single-port data memory (synchronous write,
//             combinational read) between the CPU load/store port and the
//             DMA/loader port. Round-robin arbitration with an optional
//             bounded lock for bursts, registered read-data return and
//             rejection of misaligned accesses.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             cpu_* / dma_*     - requester ports (req/we/lock/addr/wdata in,
//                                 gnt/rvalid/rdata/err out)
//             mem_we/mem_a/mem_wd/mem_rd - data memory interface
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int LOCK_MAX  = 4,     // 1..15 consecutive locked grants under contention
    parameter bit CPU_FIRST = 1'b1   // round-robin pointer after reset (1 = CPU favoured)
) (
    input  logic        clk,
    input  logic        reset,
    // CPU requester
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_lock,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    // DMA requester
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    // data memory
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_OWN_CPU  = 2'd1;
    localparam logic [1:0] c_OWN_DMA  = 2'd2;
    localparam logic [3:0] c_LOCK_MAX = 4'(LOCK_MAX);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;       // consecutive grants held by the current lock owner
    logic        r_ptr;       // 1 = CPU wins a tie, 0 = DMA wins a tie
    logic [31:0] r_last_a;
    logic [31:0] r_last_wd;
    logic        r_cpu_rvalid;
    logic [31:0] r_cpu_rdata;
    logic        r_cpu_err;
    logic        r_dma_rvalid;
    logic [31:0] r_dma_rdata;
    logic        r_dma_err;

    logic        w_cpu_pick;
    logic        w_dma_pick;
    logic        w_cpu_gnt;
    logic        w_dma_gnt;
    logic        w_any_gnt;
    logic        w_lock_spent;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_wd;
    logic        w_sel_we;
    logic        w_sel_lock;
    logic        w_aligned;

    // Counter saturates at LOCK_MAX, so equality is enough to spot an
    // exhausted lock even when the owner keeps running uncontended.
    assign w_lock_spent = (r_cnt == c_LOCK_MAX);

    always_comb begin
        w_cpu_pick = 1'b0;
        w_dma_pick = 1'b0;
        case (r_state)
            c_OWN_CPU: begin
                if (cpu_req) begin
                    if (w_lock_spent && dma_req) w_dma_pick = 1'b1;
                    else                         w_cpu_pick = 1'b1;
                end else begin
                    w_dma_pick = dma_req;
                end
            end
            c_OWN_DMA: begin
                if (dma_req) begin
                    if (w_lock_spent && cpu_req) w_cpu_pick = 1'b1;
                    else                         w_dma_pick = 1'b1;
                end else begin
                    w_cpu_pick = cpu_req;
                end
            end
            default: begin
                w_cpu_pick = cpu_req & (~dma_req | r_ptr);
                w_dma_pick = dma_req & (~cpu_req | ~r_ptr);
            end
        endcase
    end

    // No grant is issued while reset is asserted, so nothing reaches memory
    // in the reset cycle and every grant output reads 0 during reset.
    assign w_cpu_gnt = w_cpu_pick & ~reset;
    assign w_dma_gnt = w_dma_pick & ~reset;
    assign w_any_gnt = w_cpu_gnt | w_dma_gnt;

    assign w_sel_a    = w_cpu_gnt ? cpu_addr  : dma_addr;
    assign w_sel_wd   = w_cpu_gnt ? cpu_wdata : dma_wdata;
    assign w_sel_we   = w_cpu_gnt ? cpu_we    : dma_we;
    assign w_sel_lock = w_cpu_gnt ? cpu_lock  : dma_lock;
    assign w_aligned  = (w_sel_a[1:0] == 2'b00);

    assign cpu_gnt = w_cpu_gnt;
    assign dma_gnt = w_dma_gnt;
    assign mem_a   = w_any_gnt ? w_sel_a  : r_last_a;
    assign mem_wd  = w_any_gnt ? w_sel_wd : r_last_wd;
    assign mem_we  = w_any_gnt & w_sel_we & w_aligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_ptr        <= CPU_FIRST;
            r_last_a     <= 32'd0;
            r_last_wd    <= 32'd0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= 32'd0;
            r_cpu_err    <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= 32'd0;
            r_dma_err    <= 1'b0;
        end else begin
            // ownership / lock counter
            if (w_any_gnt && w_sel_lock) begin
                if (w_cpu_gnt) begin
                    r_state <= c_OWN_CPU;
                    if (r_state != c_OWN_CPU) r_cnt <= 4'd1;
                    else if (!w_lock_spent)   r_cnt <= r_cnt + 4'd1;
                end else begin
                    r_state <= c_OWN_DMA;
                    if (r_state != c_OWN_DMA) r_cnt <= 4'd1;
                    else if (!w_lock_spent)   r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_state <= c_IDLE;
                r_cnt   <= 4'd0;
            end

            // round-robin: favour the side that was not just served
            if (w_cpu_gnt)      r_ptr <= 1'b0;
            else if (w_dma_gnt) r_ptr <= 1'b1;

            if (w_any_gnt) begin
                r_last_a  <= w_sel_a;
                r_last_wd <= w_sel_wd;
            end

            // read return and misalignment report, one cycle after grant
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we & w_aligned;
            r_cpu_err    <= w_cpu_gnt & ~w_aligned;
            if (w_cpu_gnt && !cpu_we && w_aligned) r_cpu_rdata <= mem_rd;

            r_dma_rvalid <= w_dma_gnt & ~dma_we & w_aligned;
            r_dma_err    <= w_dma_gnt & ~w_aligned;
            if (w_dma_gnt && !dma_we && w_aligned) r_dma_rdata <= mem_rd;
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_err    = r_cpu_err;
    assign dma_rvalid = r_dma_rvalid;
    assign dma_rdata  = r_dma_rdata;
    assign dma_err    = r_dma_err;

endmodule
`default_nettype wire
